// File: rtl/ahb3lite_host_slave.sv
// AHB3-lite slave that tunnels each transfer as a byte stream into a host FIFO
// and completes it from the host's response byte stream.
module ahb3lite_host_slave #(
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        HSEL,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        HREADYOUT,
    output logic        WREN,
    input  logic        WRFULL,
    output logic [7:0]  WRDATA,
    output logic        RDEN,
    input  logic        RDEMPTY,
    input  logic [7:0]  RDDATA
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_ADDR, S_WDATA, S_RDATA, S_STAT, S_DONE, S_ERR1, S_ERR2
    } state_t;

    state_t      state_reg, state_next;
    logic        hwrite_reg;
    logic [1:0]  hsize_reg;
    logic [31:0] haddr_reg;
    logic [31:0] hwdata_reg;
    logic [31:0] hrdata_reg;
    logic [1:0]  cnt_reg;
    logic        dphase_reg;
    logic        pending_reg;
    logic [15:0] wait_reg;
    logic [3:0]  discard_reg;

    logic        accept;
    logic        in_recv;
    logic        sticky;
    logic        rx_byte;
    logic        timeout_hit;
    logic [7:0]  header;
    logic [7:0]  addr_bytes  [4];
    logic [7:0]  wdata_bytes [4];
    logic        unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HSIZE[2]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign addr_bytes[gi]  = haddr_reg[8*gi +: 8];
            assign wdata_bytes[gi] = hwdata_reg[8*gi +: 8];
        end
    endgenerate

    assign accept = HSEL & HREADY & (HTRANS == 2'b10) &
                    ((state_reg == S_IDLE) | (state_reg == S_DONE) | (state_reg == S_ERR2));
    assign in_recv = (state_reg == S_RDATA) | (state_reg == S_STAT);
    // Nonzero discard count means an abandoned response is still arriving.
    assign sticky  = (discard_reg != 4'd0);
    assign rx_byte = pending_reg & ~sticky & in_recv;
    assign timeout_hit = in_recv & ~pending_reg & RDEMPTY & (wait_reg == TIMEOUT - 16'd1);
    assign header  = {hwrite_reg, 5'b00000, hsize_reg};
    assign HRDATA  = hrdata_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR2: state_next = accept ? S_HDR : S_IDLE;
            S_HDR: begin
                if (!WRFULL) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (!WRFULL && cnt_reg == 2'd3) state_next = hwrite_reg ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                if (!WRFULL && cnt_reg == 2'd3) state_next = S_STAT;
            end
            S_RDATA: begin
                if (timeout_hit)                        state_next = S_ERR1;
                else if (rx_byte && cnt_reg == 2'd3)    state_next = S_STAT;
            end
            S_STAT: begin
                if (timeout_hit)  state_next = S_ERR1;
                else if (rx_byte) state_next = RDDATA[0] ? S_ERR1 : S_DONE;
            end
            S_ERR1:  state_next = S_ERR2;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b0;
        WREN      = 1'b0;
        WRDATA    = 8'h00;
        case (state_reg)
            S_IDLE, S_DONE: HREADYOUT = 1'b1;
            S_ERR1: HRESP = 1'b1;
            S_ERR2: begin
                HRESP     = 1'b1;
                HREADYOUT = 1'b1;
            end
            S_HDR: begin
                WREN   = ~WRFULL;
                WRDATA = header;
            end
            S_ADDR: begin
                WREN   = ~WRFULL;
                WRDATA = addr_bytes[cnt_reg];
            end
            S_WDATA: begin
                WREN   = ~WRFULL;
                WRDATA = wdata_bytes[cnt_reg];
            end
            default: ;
        endcase
        // One read in flight at a time; stale bytes are drained in any state.
        RDEN = (in_recv | sticky) & ~RDEMPTY & ~pending_reg;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hwrite_reg  <= 1'b0;
            hsize_reg   <= 2'd0;
            haddr_reg   <= 32'd0;
            hwdata_reg  <= 32'd0;
            hrdata_reg  <= 32'd0;
            cnt_reg     <= 2'd0;
            dphase_reg  <= 1'b0;
            pending_reg <= 1'b0;
            wait_reg    <= 16'd0;
            discard_reg <= 4'd0;
        end else begin
            dphase_reg  <= accept;
            pending_reg <= RDEN;
            if (accept) begin
                hwrite_reg <= HWRITE;
                hsize_reg  <= HSIZE[1:0];
                haddr_reg  <= HADDR;
            end
            if (dphase_reg) begin
                hwdata_reg <= HWDATA;
            end
            if (((state_reg == S_ADDR) || (state_reg == S_WDATA)) && !WRFULL) begin
                cnt_reg <= cnt_reg + 2'd1;
            end else if ((state_reg == S_RDATA) && rx_byte) begin
                cnt_reg <= cnt_reg + 2'd1;
            end else if (state_reg == S_ERR1) begin
                cnt_reg <= 2'd0;
            end
            if ((state_reg == S_RDATA) && rx_byte) begin
                hrdata_reg[{cnt_reg, 3'b000} +: 8] <= RDDATA;
            end
            if (!in_recv || pending_reg || timeout_hit) begin
                wait_reg <= 16'd0;
            end else if (RDEMPTY) begin
                wait_reg <= wait_reg + 16'd1;
            end
            // Remember how many bytes of the abandoned response are still owed.
            if (timeout_hit) begin
                discard_reg <= discard_reg +
                               ((state_reg == S_RDATA) ? (4'd5 - {2'b00, cnt_reg}) : 4'd1);
            end else if (pending_reg && sticky) begin
                discard_reg <= discard_reg - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_host_slave.sv
// Randomized scoreboard bench: expected request bytes and completions are queued
// at issue time and consumed by an independent monitor.
module tb_ahb3lite_host_slave;

    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        HSEL, HWRITE, HREADY;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HRESP, HREADYOUT, WREN, WRFULL, RDEN, RDEMPTY;
    logic [7:0]  WRDATA, RDDATA;

    assign HREADY = HREADYOUT;

    ahb3lite_host_slave #(.TIMEOUT(16'(TO))) dut (
        .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADY),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP),
        .HREADYOUT(HREADYOUT), .WREN(WREN), .WRFULL(WRFULL), .WRDATA(WRDATA),
        .RDEN(RDEN), .RDEMPTY(RDEMPTY), .RDDATA(RDDATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    int          cmp_n = 0;
    int          fail_n = 0;
    int          cyc = 0;
    logic [7:0]  exp_bytes[$];
    logic [7:0]  rsp_q[$];
    exp_t        exp_done[$];
    int          wr_cycles[$];
    int          byte_cnt = 0;
    int          stall_seen = 0;
    int          err1_cyc = -1;
    int          done_count = 0;
    int          xfer_start = 0;
    int          last_acc = 0;
    bit          rden_s = 0;
    bit          prev_rdy = 1;
    bit          prev_resp = 0;
    bit          rand_full = 0;
    bit          rand_gap = 0;
    bit          hold_empty = 0;
    int          stall_idx = -1;
    int          stall_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        cmp_n++;
        if (act !== want) begin
            fail_n++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Host-side FIFO models: response bytes appear the cycle after RDEN.
    initial begin
        WRFULL  = 1'b0;
        RDEMPTY = 1'b1;
        RDDATA  = 8'h00;
        forever begin
            @(posedge CLK);
            #1;
            if (rden_s && rsp_q.size() > 0) RDDATA = rsp_q.pop_front();
            if (stall_left > 0 && byte_cnt == stall_idx) begin
                WRFULL = 1'b1;
                stall_left--;
            end else begin
                WRFULL = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            RDEMPTY = hold_empty || (rsp_q.size() == 0) ||
                      (rand_gap && ($urandom_range(0, 3) == 0));
        end
    end

    initial forever begin
        @(negedge CLK);
        if (RESET) begin
            prev_rdy  = 1'b1;
            prev_resp = 1'b0;
            rden_s    = 1'b0;
        end else begin
            rden_s = RDEN;
            if (RDEN) check("rden_while_empty", 32'(RDEMPTY), 32'd0);
            if (WREN) begin
                check("wren_while_full", 32'(WRFULL), 32'd0);
                if (exp_bytes.size() == 0) begin
                    cmp_n++;
                    fail_n++;
                    $display("FAIL stray_byte: got %h want no byte (cycle %0d)", WRDATA, cyc);
                end else begin
                    check("req_byte", 32'(WRDATA), 32'(exp_bytes.pop_front()));
                end
                wr_cycles.push_back(cyc);
                byte_cnt++;
            end
            if (WRFULL) stall_seen++;
            if (!HREADYOUT && HRESP && err1_cyc < 0) err1_cyc = cyc;
            if (HREADYOUT && !prev_rdy) begin
                if (exp_done.size() == 0) begin
                    cmp_n++;
                    fail_n++;
                    $display("FAIL stray_completion: got hresp %b want none", HRESP);
                end else begin
                    exp_t e;
                    e = exp_done.pop_front();
                    check("hresp", 32'(HRESP), 32'(e.err));
                    if (e.err) check("err1_hresp", 32'(prev_resp), 32'd1);
                    else if (e.rd) check("hrdata", HRDATA, e.data);
                    $display("xfer %0s done: hresp=%b hrdata=%h", e.rd ? "read" : "write", HRESP, HRDATA);
                end
                done_count++;
            end
            prev_rdy  = HREADYOUT;
            prev_resp = HRESP;
        end
    end

    task automatic start_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, input logic [31:0] rdat,
                              input logic [7:0] stat, input bit provide);
        exp_t e;
        int   n;
        exp_bytes.push_back({wr, 5'b00000, sz});
        for (int i = 0; i < 4; i++) exp_bytes.push_back(a[8*i +: 8]);
        if (wr) for (int i = 0; i < 4; i++) exp_bytes.push_back(d[8*i +: 8]);
        if (provide) begin
            if (!wr) for (int i = 0; i < 4; i++) rsp_q.push_back(rdat[8*i +: 8]);
            rsp_q.push_back(stat);
        end
        e.err  = provide ? stat[0] : 1'b1;
        e.rd   = !wr;
        e.data = rdat;
        exp_done.push_back(e);
        n = 0;
        @(negedge CLK);
        while (!HREADYOUT && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!HREADYOUT) begin
            $display("FAIL ready_wait: got hreadyout 0 want 1 within 100 cycles");
            fail_n++;
            $fatal(1, "bus stuck");
        end
        byte_cnt   = 0;
        stall_seen = 0;
        err1_cyc   = -1;
        wr_cycles.delete();
        xfer_start = done_count;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR  = a;
        HSIZE  = {1'b0, sz};
        HBURST = 3'($urandom);
        HPROT  = 4'($urandom);
        HWDATA = $urandom;
        last_acc = cyc;
        @(posedge CLK);
        #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HADDR  = $urandom;
        HWDATA = wr ? d : $urandom;
        @(negedge CLK);
        check("hreadyout_low", 32'(HREADYOUT), 32'd0);
        @(posedge CLK);
        #1;
        HWDATA = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_count == xfer_start && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (done_count == xfer_start) begin
            cmp_n++;
            fail_n++;
            $display("FAIL completion_wait: got no completion want one within 400 cycles");
            exp_bytes.delete();
            exp_done.delete();
        end
        @(negedge CLK);
    endtask

    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic [31:0] rdat,
                        input logic [7:0] stat, input bit provide);
        start_xfer(wr, a, d, sz, rdat, stat, provide);
        wait_done();
    endtask

    initial begin
        logic [31:0] r;
        bit          wr;
        int          n;
        RESET  = 1'b1;
        HSEL   = 1'b0;
        HWRITE = 1'b0;
        HTRANS = 2'b00;
        HSIZE  = 3'd0;
        HBURST = 3'd0;
        HPROT  = 4'd0;
        HADDR  = 32'd0;
        HWDATA = 32'd0;
        #3;
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_wren", 32'(WREN), 32'd0);
        check("rst_wrdata", 32'(WRDATA), 32'd0);
        check("rst_rden", 32'(RDEN), 32'd0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // Unstalled word write: 9 bytes back to back, header right after acceptance.
        xfer(1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 2'd2, 32'd0, 8'h00, 1'b1);
        check("wr_nbytes", 32'(wr_cycles.size()), 32'd9);
        if (wr_cycles.size() == 9) begin
            check("hdr_latency", 32'(wr_cycles[0]), 32'(last_acc + 1));
            check("wr_span", 32'(wr_cycles[8] - wr_cycles[0]), 32'd8);
        end

        xfer(1'b0, 32'h1000_0000, 32'd0, 2'd1, 32'h1234_5678, 8'h00, 1'b1);

        // Three full cycles while address byte 2 is pending.
        stall_idx  = 3;
        stall_left = 3;
        xfer(1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 2'd2, 32'd0, 8'hFE, 1'b1);
        check("stall_cycles", 32'(stall_seen), 32'd3);
        if (wr_cycles.size() == 9) check("stall_span", 32'(wr_cycles[8] - wr_cycles[0]), 32'd11);
        stall_idx = -1;

        xfer(1'b0, 32'h0000_0100, 32'd0, 2'd2, 32'hCAFE_F00D, 8'h01, 1'b1);

        // Host never answers; its late 5 bytes must be swallowed.
        hold_empty = 1'b1;
        xfer(1'b0, 32'h3000_0010, 32'd0, 2'd2, 32'd0, 8'h00, 1'b0);
        if (wr_cycles.size() == 5) check("timeout_at", 32'(err1_cyc), 32'(wr_cycles[4] + TO + 1));
        hold_empty = 1'b0;
        rsp_q.push_back(8'h11);
        rsp_q.push_back(8'h23);
        rsp_q.push_back(8'h35);
        rsp_q.push_back(8'h47);
        rsp_q.push_back(8'h01);
        xfer(1'b1, 32'h4000_0000, 32'h0102_0304, 2'd0, 32'd0, 8'h00, 1'b1);

        // IDLE, BUSY and SEQ get a zero-wait OKAY with no bytes.
        for (int t = 0; t < 4; t++) begin
            if (t == 2) continue;
            @(negedge CLK);
            HSEL   = 1'b1;
            HTRANS = 2'(t);
            HWRITE = 1'b1;
            @(posedge CLK);
            #1;
            HSEL   = 1'b0;
            HTRANS = 2'b00;
            @(negedge CLK);
            check("nonxfer_ready", 32'(HREADYOUT), 32'd1);
            check("nonxfer_resp", 32'(HRESP), 32'd0);
            $display("htrans %0d: hreadyout=%b hresp=%b", t, HREADYOUT, HRESP);
        end

        // Reset in the middle of the address bytes.
        start_xfer(1'b1, 32'h5555_AAAA, 32'h0F0F_0F0F, 2'd2, 32'd0, 8'h00, 1'b1);
        n = 0;
        while (byte_cnt < 3 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        #2;
        RESET = 1'b1;
        #1;
        check("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("midrst_hresp", 32'(HRESP), 32'd0);
        check("midrst_hrdata", HRDATA, 32'd0);
        check("midrst_wren", 32'(WREN), 32'd0);
        check("midrst_wrdata", 32'(WRDATA), 32'd0);
        check("midrst_rden", 32'(RDEN), 32'd0);
        exp_bytes.delete();
        exp_done.delete();
        rsp_q.delete();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        xfer(1'b1, 32'h6000_0008, 32'h8765_4321, 2'd2, 32'd0, 8'h00, 1'b1);

        rand_full = 1'b1;
        rand_gap  = 1'b1;
        for (int k = 0; k < 24; k++) begin
            logic [7:0] stat;
            r    = $urandom;
            wr   = r[0];
            stat = {r[15:9], (r[4:2] == 3'd0)};
            xfer(wr, $urandom, $urandom, 2'($urandom_range(0, 2)), $urandom, stat, 1'b1);
        end
        rand_full = 1'b0;
        rand_gap  = 1'b0;
        repeat (4) @(negedge CLK);
        check("rsp_drained", 32'(rsp_q.size()), 32'd0);
        check("req_drained", 32'(exp_bytes.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
